// File: rtl/inst_mem_loader.sv
// Write-side loader for the byte-addressed instruction memory. It accepts 32-bit words over
// a valid/ready handshake and writes each word as four little-endian bytes, one per cycle.
module inst_mem_loader #(
    parameter int MEM_BYTES = 16,
    parameter int ADDR_W    = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              word_valid,
    input  logic [31:0]       word_in,
    output logic              word_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic [ADDR_W-2:0] words_loaded
);

    typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, FULL, DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-2:0] ONE_WORD  = (ADDR_W-1)'(1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_idx;
    logic [1:0]        nxt_idx;
    logic [31:0]       word_q;
    logic              last_byte;
    logic              at_top;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    assign nxt_idx    = byte_idx + 2'd1;
    assign last_byte  = (byte_idx == 2'd3);
    // The word being finished occupies the top four bytes: the memory is full after it.
    assign at_top     = (addr == LAST_WORD);
    assign word_ready = (state == ACCEPT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FULL, DONE: begin
                if (start) begin
                    state_nxt = ACCEPT;
                end
            end
            ACCEPT: begin
                if (word_valid) begin
                    state_nxt = WRITE;
                end else if (finish) begin
                    state_nxt = DONE;
                end
            end
            WRITE: begin
                if (last_byte) begin
                    state_nxt = at_top ? FULL : ACCEPT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accepted word; byte 0 is taken straight from word_in, later bytes from here.
    always_ff @(posedge clk) begin
        if ((state == ACCEPT) && word_valid) begin
            word_q <= word_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr         <= BASE;
            byte_idx     <= 2'd0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            full         <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, FULL, DONE: begin
                    if (start) begin
                        addr         <= BASE;
                        words_loaded <= '0;
                        full         <= 1'b0;
                        done         <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                ACCEPT: begin
                    if (word_valid) begin
                        byte_idx <= 2'd0;
                        wr_en    <= 1'b1;
                        wr_addr  <= addr;
                        wr_data  <= word_in[7:0];
                    end else if (finish) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                WRITE: begin
                    if (last_byte) begin
                        words_loaded <= words_loaded + ONE_WORD;
                        // Address never wraps: it stays on the last word once full.
                        if (at_top) begin
                            full <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            addr <= addr + WORD_STEP;
                        end
                    end else begin
                        byte_idx <= nxt_idx;
                        wr_en    <= 1'b1;
                        wr_addr  <= addr + ADDR_W'(nxt_idx);
                        wr_data  <= byte_of(word_q, nxt_idx);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: a transaction-level model with a byte queue is compared against
// the DUT every cycle, and directed scenarios pin the model with literal expectations.
module tb_inst_mem_loader;
    localparam int MEM_BYTES = 16;
    localparam int ADDR_W    = 4;
    localparam int BASE_ADDR = 0;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              finish;
    logic              word_valid;
    logic [31:0]       word_in;
    logic              word_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              full;
    logic              done;
    logic [ADDR_W-2:0] words_loaded;

    always #5 clk = ~clk;

    inst_mem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .word_valid(word_valid), .word_in(word_in), .word_ready(word_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .full(full), .done(done), .words_loaded(words_loaded)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model phases: 0 idle, 1 accepting, 2 writing, 3 full, 4 done.
    int  m_phase = 0;
    int  m_addr = BASE_ADDR;
    int  m_words = 0;
    bit  m_full = 0, m_done = 0, m_busy = 0, m_wr_en = 0;
    int  m_wr_addr = 0, m_wr_data = 0;
    int  q_addr[$];
    int  q_data[$];
    bit  started = 0;

    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            m_phase = 0; m_addr = BASE_ADDR; m_words = 0;
            m_full = 0; m_done = 0; m_busy = 0; m_wr_en = 0;
            m_wr_addr = 0; m_wr_data = 0;
            q_addr.delete(); q_data.delete();
        end else begin
            m_wr_en = 0;
            case (m_phase)
                0, 3, 4: if (start) begin
                    m_phase = 1; m_addr = BASE_ADDR; m_words = 0;
                    m_full = 0; m_done = 0; m_busy = 1;
                end
                1: if (word_valid) begin
                    for (int k = 0; k < 4; k++) begin
                        q_addr.push_back(m_addr + k);
                        q_data.push_back(int'((word_in >> (8 * k)) & 32'hFF));
                    end
                    m_phase = 2;
                end else if (finish) begin
                    m_phase = 4; m_done = 1; m_busy = 0;
                end
                default: ;
            endcase
            if (m_phase == 2) begin
                if (q_addr.size() > 0) begin
                    m_wr_en = 1;
                    m_wr_addr = q_addr.pop_front();
                    m_wr_data = q_data.pop_front();
                end else begin
                    m_words++;
                    if (m_addr + 4 >= MEM_BYTES) begin
                        m_phase = 3; m_full = 1; m_busy = 0;
                    end else begin
                        m_addr += 4; m_phase = 1;
                    end
                end
            end
        end
    end

    int log_addr[$];
    int log_data[$];

    always @(negedge clk) begin
        if (started) begin
            check("word_ready", int'(word_ready), int'(m_phase == 1));
            check("wr_en", int'(wr_en), int'(m_wr_en));
            check("wr_addr", int'(wr_addr), m_wr_addr);
            check("wr_data", int'(wr_data), m_wr_data);
            check("busy", int'(busy), int'(m_busy));
            check("full", int'(full), int'(m_full));
            check("done", int'(done), int'(m_done));
            check("words_loaded", int'(words_loaded), m_words);
            if (wr_en) begin
                log_addr.push_back(int'(wr_addr));
                log_data.push_back(int'(wr_data));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] w4 [4];
    int          t2_bytes [4];

    initial begin
        w4 = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        t2_bytes = '{8'h83, 8'h34, 8'h85, 8'h02};

        // Reset with start and valid held high
        reset = 1; start = 1; finish = 0; word_valid = 1; word_in = 32'hFFFFFFFF;
        tick(2);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(word_ready), 0);
        check("rst_words", int'(words_loaded), 0);
        check("rst_full_done", int'({full, done}), 0);
        check("rst_wr_bus", int'({wr_addr, wr_data}), 0);
        reset = 0; start = 0; word_valid = 0;
        tick(1);

        // Single word byte order
        start = 1; tick(1); start = 0;
        clear_log();
        word_in = 32'h02853483; word_valid = 1; tick(1); word_valid = 0;
        tick(4);
        check("t2_nwrites", log_addr.size(), 4);
        for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
            check("t2_addr", log_addr[k], k);
            check("t2_data", log_data[k], t2_bytes[k]);
        end
        check("t2_ready_T5", int'(word_ready), 1);
        check("t2_words", int'(words_loaded), 1);
        finish = 1; tick(1); finish = 0;
        check("t2_done", int'(done), 1);

        // Fill the memory with word_valid held high
        start = 1; tick(1); start = 0;
        clear_log();
        word_valid = 1;
        for (int i = 0; i < 4; i++) begin
            word_in = w4[i];
            tick(5);
        end
        check("t3_full", int'(full), 1);
        check("t3_busy", int'(busy), 0);
        check("t3_words", int'(words_loaded), 4);
        word_in = 32'hCAFEF00D;
        tick(6);
        word_valid = 0;
        check("t3_nwrites", log_addr.size(), 16);
        for (int k = 0; k < 16 && k < log_addr.size(); k++) begin
            check("t3_addr", log_addr[k], k);
        end
        if (log_data.size() == 16) begin
            check("t3_first_byte", log_data[0], 8'h44);
            check("t3_last_byte", log_data[15], 8'hDD);
        end
        check("t3_ready_full", int'(word_ready), 0);

        // Two words, finish, then restart
        start = 1; tick(1); start = 0;
        check("t4_full_clr", int'(full), 0);
        check("t4_busy", int'(busy), 1);
        word_valid = 1; word_in = 32'hA1B2C3D4; tick(5);
        word_in = 32'h0BADF00D; tick(5); word_valid = 0;
        finish = 1; tick(1); finish = 0;
        check("t4_done", int'(done), 1);
        check("t4_words", int'(words_loaded), 2);
        check("t4_busy_end", int'(busy), 0);
        start = 1; tick(1); start = 0;
        check("t4_done_clr", int'(done), 0);
        check("t4_words_clr", int'(words_loaded), 0);
        clear_log();
        word_in = 32'h12345678; word_valid = 1; tick(1); word_valid = 0;
        tick(1);
        check("t4_first_wr_n", log_addr.size(), 1);
        if (log_addr.size() > 0) begin
            check("t4_first_addr", log_addr[0], 0);
            check("t4_first_data", log_data[0], 8'h78);
        end
        tick(3);

        // Reset in the cycle writing byte 2 of the second word
        check("t5_words_pre", int'(words_loaded), 1);
        word_in = 32'hDEADBEEF; word_valid = 1; tick(1); word_valid = 0;
        tick(2);
        check("t5_wr_en_b2", int'(wr_en), 1);
        check("t5_addr_b2", int'(wr_addr), 6);
        reset = 1; tick(1); reset = 0;
        check("t5_wr_en", int'(wr_en), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_ready", int'(word_ready), 0);
        check("t5_words", int'(words_loaded), 0);
        tick(1);

        // word_valid and finish together
        start = 1; tick(1); start = 0;
        word_in = 32'h0000ABCD; word_valid = 1; finish = 1; tick(1);
        word_valid = 0; finish = 0;
        tick(4);
        check("t6_ready", int'(word_ready), 1);
        check("t6_done", int'(done), 0);
        check("t6_words", int'(words_loaded), 1);
        check("t6_busy", int'(busy), 1);
        finish = 1; tick(1); finish = 0;
        check("t6_done_end", int'(done), 1);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
